n0prime_arbiter: RTL and testbench

//  Shares one n0prime512 inverse/Montgomery-constant engine between NREQ requesters
//  in the RSA-CRT decryption core (e.g. p-path and q-path precompute).

---
 rtl/n0prime_arbiter_if.sv | 39 +++
 rtl/n0prime_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_n0prime_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/n0prime_arbiter_if.sv
// Bundle of requester, response and engine signals for n0prime_arbiter.
// The arbiter connects through the slave modport; the surrounding system
// (requesters, consumer, engine) connects through the master modport.
interface n0prime_arbiter_if #(
  parameter int W    = 512,
  parameter int NREQ = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_p;
  logic [NREQ*W-1:0] req_q;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_qinv;
  logic [W-1:0]      rsp_t;
  logic              rsp_err;
  logic [W-1:0]      eng_p;
  logic [W-1:0]      eng_q;
  logic              eng_start;
  logic              eng_done;
  logic [W-1:0]      eng_qinv;
  logic [W-1:0]      eng_t;
  logic              busy;

  modport slave (
    input  req_valid, req_p, req_q, rsp_ready, eng_done, eng_qinv, eng_t,
    output req_ready, rsp_valid, rsp_id, rsp_qinv, rsp_t, rsp_err,
           eng_p, eng_q, eng_start, busy
  );

  modport master (
    output req_valid, req_p, req_q, rsp_ready, eng_done, eng_qinv, eng_t,
    input  req_ready, rsp_valid, rsp_id, rsp_qinv, rsp_t, rsp_err,
           eng_p, eng_q, eng_start, busy
  );
endinterface

// File: rtl/n0prime_arbiter.sv
// Round-robin arbiter sharing one n0prime inverse engine between NREQ
// requesters. One job in flight: grant, hold eng_start for START_LEN cycles,
// wait for eng_done (or watchdog expiry), present the tagged response.
module n0prime_arbiter #(
  parameter int W         = 512,
  parameter int NREQ      = 2,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  n0prime_arbiter_if.slave    bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One counter serves both the launch length and the watchdog.
  localparam int CMAX = (TIMEOUT > START_LEN) ? TIMEOUT : START_LEN + 1;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] START_LAST = CW'(START_LEN - 1);
  localparam logic [CW-1:0] WD_LAST    = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    eng_p_q, eng_p_d;
  logic [W-1:0]    eng_q_q, eng_q_d;
  logic            eng_start_q, eng_start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_qinv_q, rsp_qinv_d;
  logic [W-1:0]    rsp_t_q, rsp_t_d;
  logic            rsp_err_q, rsp_err_d;

  logic            any_s;
  logic [IDW-1:0]  grant_id_s;
  logic [IDW-1:0]  cand_s;
  logic [NREQ-1:0] grant_oh_s;

  // Successor of a requester index, wrapping NREQ-1 back to 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (int'(id) >= NREQ - 1) begin
      return '0;
    end else begin
      return id + IDW'(1'b1);
    end
  endfunction

  // Round-robin pick: scan downward from the farthest candidate so the one
  // closest to rr_ptr is the last writer and therefore wins.
  always_comb begin
    any_s      = 1'b0;
    grant_id_s = '0;
    cand_s     = '0;
    grant_oh_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s     = IDW'((int'(rr_ptr_q) + k) % NREQ);
      grant_id_s = bus.req_valid[cand_s] ? cand_s : grant_id_s;
      any_s      = any_s | bus.req_valid[cand_s];
    end
    if ((state_q == ST_IDLE) && any_s) begin
      grant_oh_s[grant_id_s] = 1'b1;
    end else begin
      grant_oh_s = '0;
    end
  end

  // Next-state and datapath update for the job FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    eng_p_d     = eng_p_q;
    eng_q_d     = eng_q_q;
    eng_start_d = eng_start_q;
    rsp_valid_d = rsp_valid_q;
    rsp_qinv_d  = rsp_qinv_q;
    rsp_t_d     = rsp_t_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          id_d        = grant_id_s;
          eng_p_d     = bus.req_p[grant_id_s*W +: W];
          eng_q_d     = bus.req_q[grant_id_s*W +: W];
          cnt_d       = '0;
          eng_start_d = 1'b1;
          state_d     = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        // eng_done is deliberately not looked at until the launch is over.
        if (cnt_q == START_LAST) begin
          cnt_d       = '0;
          eng_start_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      ST_WAIT: begin
        // A done arriving on the watchdog's last cycle still delivers data.
        if (bus.eng_done) begin
          rsp_qinv_d  = bus.eng_qinv;
          rsp_t_d     = bus.eng_t;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == WD_LAST) begin
          rsp_qinv_d  = '0;
          rsp_t_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = next_id(id_q);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        eng_start_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      eng_p_q     <= '0;
      eng_q_q     <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_qinv_q  <= '0;
      rsp_t_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      eng_p_q     <= eng_p_d;
      eng_q_q     <= eng_q_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_qinv_q  <= rsp_qinv_d;
      rsp_t_q     <= rsp_t_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = grant_oh_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_qinv  = rsp_qinv_q;
  assign bus.rsp_t     = rsp_t_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.eng_p     = eng_p_q;
  assign bus.eng_q     = eng_q_q;
  assign bus.eng_start = eng_start_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_n0prime_arbiter.sv
// Scoreboard bench for n0prime_arbiter: directed jobs push expected
// responses; a monitor pops and compares on each response handshake.
module tb_n0prime_arbiter;

  localparam int W         = 512;
  localparam int NREQ      = 2;
  localparam int START_LEN = 2;
  localparam int TIMEOUT   = 64;

  localparam logic [W-1:0] P0 = 512'h5A5A_0000_0000_1111_00A3_9851;
  localparam logic [W-1:0] Q0 = 512'h3C3C_0000_0000_2222_0087_D229;
  localparam logic [W-1:0] P1 = 512'h7777_0000_0000_3333_0012_3457;
  localparam logic [W-1:0] Q1 = 512'h9999_0000_0000_4444_00FE_DCB9;

  typedef struct {
    int           id;
    logic [W-1:0] qinv;
    logic [W-1:0] t;
    logic         err;
  } exp_rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks      = 0;
  int   failures    = 0;
  int   start_cycles = 0;
  int   base;
  int   n;
  exp_rsp_t sb_q[$];

  always #5 clk = ~clk;

  n0prime_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  n0prime_arbiter #(
    .W(W), .NREQ(NREQ), .START_LEN(START_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] qi, input logic [W-1:0] ti,
                          input logic err);
    exp_rsp_t e;
    e.id = id; e.qinv = qi; e.t = ti; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles in which eng_start was high.
  always @(posedge clk) begin
    if (bus.eng_start === 1'b1) start_cycles <= start_cycles + 1;
  end

  // Response monitor: compares every accepted response with the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got id=%0d err=%0b expected no response",
                 bus.rsp_id, bus.rsp_err);
      end else begin
        exp_rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_id",   W'(bus.rsp_id), W'(e.id));
        chk("rsp_qinv", bus.rsp_qinv, e.qinv);
        chk("rsp_t",    bus.rsp_t, e.t);
        chk("rsp_err",  W'(bus.rsp_err), W'(e.err));
      end
    end
  end

  // Waits (bounded) for a grant and checks the one-hot pattern.
  task automatic expect_grant(input string name, input logic [1:0] exp_oh);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, W'(bus.req_ready), W'(exp_oh));
  endtask

  // Waits (bounded) until launch is over; checks launch length and operands.
  task automatic wait_launch(input int b, input logic [W-1:0] ep, input logic [W-1:0] eq);
    int k;
    k = 0;
    while (!(bus.eng_start === 1'b0 && start_cycles > b) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("start_len", W'(start_cycles - b), W'(START_LEN));
    chk("eng_p", bus.eng_p, ep);
    chk("eng_q", bus.eng_q, eq);
  endtask

  task automatic run_engine(input int delay, input logic [W-1:0] qi, input logic [W-1:0] ti,
                            input logic [W-1:0] ep, input logic [W-1:0] eq, input int b);
    wait_launch(b, ep, eq);
    step();
    repeat (delay) step();
    chk("eng_p_hold", bus.eng_p, ep);
    bus.eng_done = 1'b1;
    bus.eng_qinv = qi;
    bus.eng_t    = ti;
    step();
    bus.eng_done = 1'b0;
    bus.eng_qinv = ~qi;
    bus.eng_t    = ~ti;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d responses outstanding expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_p     = {P1, P0};
    bus.req_q     = {Q1, Q0};
    bus.rsp_ready = 1'b1;
    bus.eng_done  = 1'b0;
    bus.eng_qinv  = '0;
    bus.eng_t     = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_ready", W'(bus.req_ready), W'(2'b00));
    chk("rst_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
    chk("rst_eng_start", W'(bus.eng_start), W'(1'b0));
    chk("rst_busy",      W'(bus.busy), W'(1'b0));
    chk("rst_eng_p",     bus.eng_p, '0);
    chk("rst_rsp_qinv",  bus.rsp_qinv, '0);
    chk("rst_rsp_err",   W'(bus.rsp_err), W'(1'b0));
    step();
    rst = 1'b0;

    // Single job from requester 0
    bus.req_valid = 2'b01;
    push_exp(0, 512'h1234, 512'h5678, 1'b0);
    expect_grant("t1_grant", 2'b01);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t1_ready_drop", W'(bus.req_ready), W'(2'b00));
    run_engine(48, 512'h1234, 512'h5678, P0, Q0, base);
    wait_drain("t1_rsp", 50);

    // Stray done in IDLE, then stray done during LAUNCH of requester 1
    step();
    step();
    bus.eng_done = 1'b1;
    bus.eng_qinv = 512'hDEAD;
    step();
    bus.eng_done = 1'b0;
    @(negedge clk);
    chk("t6_idle_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
    chk("t6_idle_busy", W'(bus.busy), W'(1'b0));
    step();
    bus.req_valid = 2'b10;
    push_exp(1, 512'hAAAA, 512'hBBBB, 1'b0);
    expect_grant("t6_grant", 2'b10);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    bus.eng_done  = 1'b1;
    bus.eng_qinv  = 512'hBAD1;
    bus.eng_t     = 512'hBAD2;
    step();
    bus.eng_done  = 1'b0;
    run_engine(10, 512'hAAAA, 512'hBBBB, P1, Q1, base);
    wait_drain("t6_rsp", 50);

    // Fairness with both requesters held valid
    bus.req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      int e;
      e = j % 2;
      push_exp(e, W'(256 + j), W'(512 + j), 1'b0);
      expect_grant($sformatf("t2_grant%0d", j), 2'(1 << e));
      base = start_cycles;
      step();
      run_engine(5 + j, W'(256 + j), W'(512 + j), (e == 1) ? P1 : P0, (e == 1) ? Q1 : Q0, base);
      wait_drain($sformatf("t2_rsp%0d", j), 50);
    end
    bus.req_valid = 2'b00;

    // Backpressure on the response
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    push_exp(0, 512'h3333, 512'h4444, 1'b0);
    expect_grant("t3_grant", 2'b01);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    run_engine(3, 512'h3333, 512'h4444, P0, Q0, base);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    step();
    bus.req_valid = 2'b10;
    push_exp(1, 512'h5555, 512'h6666, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("t3_rsp_valid", W'(bus.rsp_valid), W'(1'b1));
      chk("t3_rsp_qinv", bus.rsp_qinv, 512'h3333);
      chk("t3_rsp_t", bus.rsp_t, 512'h4444);
      chk("t3_req_ready", W'(bus.req_ready), W'(2'b00));
      chk("t3_eng_start", W'(bus.eng_start), W'(1'b0));
    end
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle_busy", W'(bus.busy), W'(1'b0));
    chk("t3_next_grant", W'(bus.req_ready), W'(2'b10));
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    run_engine(4, 512'h5555, 512'h6666, P1, Q1, base);
    wait_drain("t3_rsp", 50);

    // Hung engine: watchdog error response, then a normal job
    step();
    bus.req_valid = 2'b01;
    push_exp(0, '0, '0, 1'b1);
    expect_grant("t4_grant", 2'b01);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    wait_launch(base, P0, Q0);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < TIMEOUT + 20) begin
      n++;
      @(negedge clk);
    end
    chk("t4_wait_cycles", W'(n), W'(TIMEOUT));
    wait_drain("t4_rsp", 10);
    step();
    bus.req_valid = 2'b10;
    push_exp(1, 512'h7777, 512'h8888, 1'b0);
    expect_grant("t4_next_grant", 2'b10);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    run_engine(6, 512'h7777, 512'h8888, P1, Q1, base);
    wait_drain("t4_next_rsp", 50);

    // Reset while waiting for the engine
    step();
    bus.req_valid = 2'b01;
    expect_grant("t5_grant", 2'b01);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    wait_launch(base, P0, Q0);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", W'(bus.busy), W'(1'b0));
    chk("t5_eng_start", W'(bus.eng_start), W'(1'b0));
    chk("t5_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
    chk("t5_eng_p", bus.eng_p, '0);
    step();
    bus.eng_done = 1'b1;
    bus.eng_qinv = 512'hBEEF;
    step();
    bus.eng_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t5_late_done", W'(bus.rsp_valid), W'(1'b0));
    end
    step();
    bus.req_valid = 2'b11;
    push_exp(0, 512'h9999, 512'hAAAA, 1'b0);
    expect_grant("t5_after_rst_grant", 2'b01);
    base = start_cycles;
    step();
    bus.req_valid = 2'b00;
    run_engine(2, 512'h9999, 512'hAAAA, P0, Q0, base);
    wait_drain("t5_rsp", 50);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
